// File: rtl/scc_mem_arbiter.sv
// Fetch/data arbiter for the single-ported SCC memory: one access in flight,
// data-port priority with a fetch anti-starvation override. Optional perf counters: SCC_ARB_PERF_EN.
module scc_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              if_req_v,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_rdy,
    output logic              if_rsp_v,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_v,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_rdy,
    output logic              d_rsp_v,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef SCC_ARB_PERF_EN
    ,
    output logic [15:0]       perf_if_grants,
    output logic [15:0]       perf_d_grants,
    output logic [15:0]       perf_conflict_cycles
`endif
);

    // state | meaning
    // IDLE  | no transaction, arbitrating
    // ISSUE | mem_en high for one cycle with latched request
    // WAIT  | counting down memory latency, rdata captured on the last cycle
    // RESP  | owner's rsp_v pulses; arbitrates like IDLE
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);
    localparam logic [1:0] LAT_M1   = 2'(MEM_LAT - 1);

    state_t            state_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              owner_d_q;
    logic              we_q;
    logic [1:0]        lat_q;
    logic              if_rsp_v_q;
    logic              d_rsp_v_q;
    logic [DATA_W-1:0] if_rsp_data_q;
    logic [DATA_W-1:0] d_rsp_data_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic arb_phase;
    logic grant_if;
    logic grant_d;
    logic accept_ok;
    logic accept;

    assign arb_phase = (state_q == S_IDLE) || (state_q == S_RESP);
    assign grant_if  = if_req_v && (!d_req_v || (starve_q == STARVE_C));
    assign grant_d   = d_req_v && !grant_if;
    // Reset must win over a same-edge accept, so rdy is masked while rst is high.
    assign accept_ok = arb_phase && clk_en && !rst;
    assign if_req_rdy = accept_ok && grant_if;
    assign d_req_rdy  = accept_ok && grant_d;
    assign accept     = if_req_rdy || d_req_rdy;

    always_comb begin
        starve_d = starve_q;
        if (arb_phase) begin
            if (!if_req_v || grant_if) begin
                starve_d = '0;
            end else if (starve_q != STARVE_C) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            starve_q      <= '0;
            owner_d_q     <= 1'b0;
            we_q          <= 1'b0;
            lat_q         <= '0;
            if_rsp_v_q    <= 1'b0;
            d_rsp_v_q     <= 1'b0;
            if_rsp_data_q <= '0;
            d_rsp_data_q  <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else if (clk_en) begin
            starve_q <= starve_d;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if_rsp_v_q <= 1'b0;
                    d_rsp_v_q  <= 1'b0;
                    if (accept) begin
                        state_q   <= S_ISSUE;
                        owner_d_q <= grant_d;
                        mem_en_q  <= 1'b1;
                        if (grant_d) begin
                            we_q        <= d_req_we;
                            mem_we_q    <= d_req_we;
                            mem_addr_q  <= d_req_addr;
                            mem_wdata_q <= d_req_wdata;
                        end else begin
                            we_q       <= 1'b0;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= if_req_addr;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    lat_q    <= LAT_M1;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_q == 2'd0) begin
                        state_q <= S_RESP;
                        if (owner_d_q) begin
                            d_rsp_v_q    <= 1'b1;
                            d_rsp_data_q <= we_q ? '0 : mem_rdata;
                        end else begin
                            if_rsp_v_q    <= 1'b1;
                            if_rsp_data_q <= mem_rdata;
                        end
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_rsp_v    = if_rsp_v_q;
    assign if_rsp_data = if_rsp_data_q;
    assign d_rsp_v     = d_rsp_v_q;
    assign d_rsp_data  = d_rsp_data_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

`ifdef SCC_ARB_PERF_EN
    logic [15:0] perf_if_q;
    logic [15:0] perf_d_q;
    logic [15:0] perf_conf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_q   <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else if (clk_en) begin
            if (if_req_rdy && (perf_if_q != 16'hFFFF)) begin
                perf_if_q <= perf_if_q + 16'd1;
            end
            if (d_req_rdy && (perf_d_q != 16'hFFFF)) begin
                perf_d_q <= perf_d_q + 16'd1;
            end
            if (arb_phase && if_req_v && d_req_v && (perf_conf_q != 16'hFFFF)) begin
                perf_conf_q <= perf_conf_q + 16'd1;
            end
        end
    end

    assign perf_if_grants       = perf_if_q;
    assign perf_d_grants        = perf_d_q;
    assign perf_conflict_cycles = perf_conf_q;
`endif

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Bench for scc_mem_arbiter: directed scenarios plus a random phase, all cycles
// checked against a transaction-level reference model of arbitration and timing.
module tb_scc_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic          clk;
    logic          rst;
    logic          clk_en;
    logic          if_req_v;
    logic [AW-1:0] if_req_addr;
    logic          if_req_rdy;
    logic          if_rsp_v;
    logic [DW-1:0] if_rsp_data;
    logic          d_req_v;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_req_rdy;
    logic          d_rsp_v;
    logic [DW-1:0] d_rsp_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef SCC_ARB_PERF_EN
    logic [15:0]   perf_if_grants;
    logic [15:0]   perf_d_grants;
    logic [15:0]   perf_conflict_cycles;
`endif

    scc_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .if_req_v(if_req_v), .if_req_addr(if_req_addr), .if_req_rdy(if_req_rdy),
        .if_rsp_v(if_rsp_v), .if_rsp_data(if_rsp_data),
        .d_req_v(d_req_v), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_rdy(d_req_rdy),
        .d_rsp_v(d_rsp_v), .d_rsp_data(d_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef SCC_ARB_PERF_EN
        ,
        .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_conflict_cycles(perf_conflict_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return (a == 8'h04) ? 32'hDEADBEEF : {16'hC0DE, 8'h00, a};
    endfunction

    // Memory macro stand-in: read data is valid only in the cycle ISSUE+LAT.
    logic          mem_clr;
    logic [31:0]   dev_mem [256];
    logic [7:0]    rd_addr;
    logic [3:0]    since;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int a = 0; a < 256; a++) dev_mem[a] <= init_word(8'(a));
        end
        if (rst) begin
            since   <= 4'd0;
            rd_addr <= 8'd0;
        end else if (clk_en) begin
            if (mem_en) begin
                since   <= 4'd1;
                rd_addr <= mem_addr[7:0];
                if (mem_we) dev_mem[mem_addr[7:0]] <= mem_wdata;
            end else if (since != 4'd0 && since != 4'd15) begin
                since <= since + 4'd1;
            end
        end
    end

    assign mem_rdata = (since == 4'(LAT)) ? dev_mem[rd_addr] : (32'hBAD0_0000 | 32'(since));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: cycles-until-next-arbitration plus pending response.
    logic [31:0] model_mem [256];
    int          m_busy;
    int          m_starve;
    bit          m_pend;
    bit          m_own_d;
    bit          m_iss_we;
    logic [15:0] m_iss_addr;
    logic [31:0] m_iss_wdata;
    logic [31:0] m_resp_data;
    logic [31:0] m_if_data;
    logic [31:0] m_d_data;
    int          m_if_gr, m_d_gr, m_conf;

    int cyc;
    bit if_acc, d_acc;
    int last_if_acc_cyc, last_d_acc_cyc, last_if_rsp_cyc, last_d_rsp_cyc;
    int n_if_rsp, n_d_rsp;

    task automatic model_reset();
        m_busy = 0; m_starve = 0; m_pend = 0; m_own_d = 0; m_iss_we = 0;
        m_iss_addr = '0; m_iss_wdata = '0; m_resp_data = '0;
        m_if_data = '0; m_d_data = '0;
        m_if_gr = 0; m_d_gr = 0; m_conf = 0;
    endtask

    task automatic step();
        bit arb, g_if, g_d, e_ifr, e_dr, e_iss;
        #1;
        arb   = (m_busy == 0);
        g_if  = if_req_v && (!d_req_v || m_starve == SMAX);
        g_d   = d_req_v && !g_if;
        e_ifr = arb && clk_en && g_if;
        e_dr  = arb && clk_en && g_d;
        e_iss = (m_busy == LAT + 1);
        if (!rst) begin
            chk("if_req_rdy", 64'(if_req_rdy), 64'(e_ifr));
            chk("d_req_rdy", 64'(d_req_rdy), 64'(e_dr));
            chk("if_rsp_v", 64'(if_rsp_v), 64'(arb && m_pend && !m_own_d));
            chk("d_rsp_v", 64'(d_rsp_v), 64'(arb && m_pend && m_own_d));
            chk("if_rsp_data", 64'(if_rsp_data), 64'(m_if_data));
            chk("d_rsp_data", 64'(d_rsp_data), 64'(m_d_data));
            chk("mem_en", 64'(mem_en), 64'(e_iss));
            if (e_iss) begin
                chk("mem_addr", 64'(mem_addr), 64'(m_iss_addr));
                chk("mem_we", 64'(mem_we), 64'(m_iss_we));
                if (m_iss_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_iss_wdata));
            end
            if (if_rsp_v === 1'b1) begin last_if_rsp_cyc = cyc; n_if_rsp++; end
            if (d_rsp_v === 1'b1) begin last_d_rsp_cyc = cyc; n_d_rsp++; end
        end
        if_acc = e_ifr && !rst;
        d_acc  = e_dr && !rst;
        if (if_acc) last_if_acc_cyc = cyc;
        if (d_acc) last_d_acc_cyc = cyc;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (clk_en) begin
            if (arb) begin
                m_pend = 0;
                if (if_req_v && d_req_v && m_conf < 16'hFFFF) m_conf++;
                if (!if_req_v || g_if) m_starve = 0;
                else if (m_starve < SMAX) m_starve++;
                if (if_acc || d_acc) begin
                    m_busy  = LAT + 1;
                    m_own_d = d_acc;
                    if (d_acc) begin
                        m_d_gr++;
                        m_iss_we    = d_req_we;
                        m_iss_addr  = d_req_addr;
                        m_iss_wdata = d_req_wdata;
                        m_resp_data = d_req_we ? 32'h0 : model_mem[d_req_addr[7:0]];
                        if (d_req_we) model_mem[d_req_addr[7:0]] = d_req_wdata;
                    end else begin
                        m_if_gr++;
                        m_iss_we    = 1'b0;
                        m_iss_addr  = if_req_addr;
                        m_resp_data = model_mem[if_req_addr[7:0]];
                    end
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_pend = 1;
                    if (m_own_d) m_d_data = m_resp_data;
                    else m_if_data = m_resp_data;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int n_d_wins;
    bit if_hold, d_hold;

    initial begin
        rst = 1'b1; clk_en = 1'b1; mem_clr = 1'b1;
        if_req_v = 1'b0; if_req_addr = '0;
        d_req_v = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
        cyc = 0; n_if_rsp = 0; n_d_rsp = 0;
        last_if_acc_cyc = -100; last_d_acc_cyc = -100;
        last_if_rsp_cyc = -100; last_d_rsp_cyc = -100;
        for (int a = 0; a < 256; a++) model_mem[a] = init_word(8'(a));
        model_reset();
        step();
        step();
        mem_clr = 1'b0;
        rst = 1'b0;

        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_if_rsp_v", 64'(if_rsp_v), 64'd0);
        chk("rst_d_rsp_data", 64'(d_rsp_data), 64'd0);

        // Fetch read of 0x0004
        if_req_v = 1'b1; if_req_addr = 16'h0004;
        step();
        chk("t1_accept", 64'(if_acc), 64'd1);
        if_req_v = 1'b0;
        drain(LAT + 4);
        chk("t1_latency", 64'(last_if_rsp_cyc - last_if_acc_cyc), 64'(2 + LAT));
        chk("t1_data", 64'(if_rsp_data), 64'h0000_0000_DEAD_BEEF);
        chk("t1_no_d_rsp", 64'(n_d_rsp), 64'd0);

        // Data write of 0x12345678 to 0x0010
        d_req_v = 1'b1; d_req_we = 1'b1; d_req_addr = 16'h0010; d_req_wdata = 32'h12345678;
        step();
        chk("t2_accept", 64'(d_acc), 64'd1);
        d_req_v = 1'b0; d_req_we = 1'b0;
        drain(LAT + 4);
        chk("t2_latency", 64'(last_d_rsp_cyc - last_d_acc_cyc), 64'(2 + LAT));
        chk("t2_data", 64'(d_rsp_data), 64'd0);

        // Both valid: data first, fetch in the following RESP
        if_req_v = 1'b1; if_req_addr = 16'h0010;
        d_req_v = 1'b1; d_req_addr = 16'h0004;
        step();
        chk("t3_d_first", 64'({d_acc, if_acc}), 64'b10);
        d_req_v = 1'b0;
        for (int i = 0; i < 10 && !if_acc; i++) step();
        if_req_v = 1'b0;
        chk("t3_if_in_resp", 64'(last_if_acc_cyc - last_d_acc_cyc), 64'(2 + LAT));
        drain(LAT + 4);
        chk("t3_if_data", 64'(if_rsp_data), 64'h0000_0000_1234_5678);

        // Starvation: data held valid with fetch waiting
        n_d_wins = 0;
        if_req_v = 1'b1; if_req_addr = 16'h0003;
        d_req_v = 1'b1; d_req_addr = 16'h0005;
        if_acc = 1'b0;
        for (int i = 0; i < 80 && !if_acc; i++) begin
            step();
            if (d_acc) begin
                n_d_wins++;
                d_req_addr = 16'($urandom_range(0, 15));
            end
        end
        chk("t4_fetch_won", 64'(if_acc), 64'd1);
        chk("t4_d_wins", 64'(n_d_wins), 64'(SMAX));
        if_req_addr = 16'h0006;
        if_acc = 1'b0; d_acc = 1'b0;
        for (int i = 0; i < 12 && !(if_acc || d_acc); i++) step();
        chk("t4_counter_cleared", 64'({d_acc, if_acc}), 64'b10);
        if_req_v = 1'b0; d_req_v = 1'b0;
        drain(LAT + 4);

        // Reset during WAIT drops the transaction
        if_req_v = 1'b1; if_req_addr = 16'h0004;
        step();
        if_req_v = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_mem_en", 64'(mem_en), 64'd0);
        chk("t5_mem_addr", 64'(mem_addr), 64'd0);
        chk("t5_mem_we", 64'(mem_we), 64'd0);
        chk("t5_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("t5_rsp_v", 64'({if_rsp_v, d_rsp_v}), 64'd0);
        chk("t5_if_data", 64'(if_rsp_data), 64'd0);
        chk("t5_d_data", 64'(d_rsp_data), 64'd0);
        n_if_rsp = 0;
        drain(LAT + 6);
        chk("t5_no_rsp", 64'(n_if_rsp), 64'd0);
        d_req_v = 1'b1; d_req_we = 1'b0; d_req_addr = 16'h0007;
        step();
        chk("t5_new_accept", 64'(d_acc), 64'd1);
        d_req_v = 1'b0;
        drain(LAT + 4);

        // clk_en low for 5 cycles during WAIT delays the response by 5
        d_req_v = 1'b1; d_req_addr = 16'h0009;
        step();
        d_req_v = 1'b0;
        step();
        step();
        clk_en = 1'b0;
        if_req_v = 1'b1; if_req_addr = 16'h0001;
        drain(5);
        if_req_v = 1'b0;
        clk_en = 1'b1;
        drain(LAT + 4);
        chk("t6_delay", 64'(last_d_rsp_cyc - last_d_acc_cyc), 64'(2 + LAT + 5));
        chk("t6_data", 64'(d_rsp_data), 64'(init_word(8'h09)));

        // Random traffic against the model
        if_hold = 0; d_hold = 0;
        for (int n = 0; n < 2000; n++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            if (!if_hold) begin
                if ($urandom_range(0, 1) == 1) begin
                    if_req_v = 1'b1; if_req_addr = 16'($urandom_range(0, 15)); if_hold = 1;
                end else begin
                    if_req_v = 1'b0;
                end
            end
            if (!d_hold) begin
                if ($urandom_range(0, 2) != 0) begin
                    d_req_v = 1'b1; d_req_we = 1'($urandom_range(0, 1));
                    d_req_addr = 16'($urandom_range(0, 15)); d_req_wdata = $urandom; d_hold = 1;
                end else begin
                    d_req_v = 1'b0;
                end
            end
            step();
            if (if_acc) if_hold = 0;
            if (d_acc) d_hold = 0;
        end
        clk_en = 1'b1; if_req_v = 1'b0; d_req_v = 1'b0;
        drain(LAT + 6);

`ifdef SCC_ARB_PERF_EN
        chk("perf_if_grants", 64'(perf_if_grants), 64'(m_if_gr));
        chk("perf_d_grants", 64'(perf_d_grants), 64'(m_d_gr));
        chk("perf_conflict_cycles", 64'(perf_conflict_cycles), 64'(m_conf));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
